stopwatch_ctrl: RTL

- Mode controller and timebase owner for the board's MM:SS stopwatch/clock display.
- Contains the programmable tick divider. It selects the 1 Hz run rate or the 2 Hz fast-adjust rate, gates the divider per mode, and sequences the BCD time registers.
- Button inputs arrive as clean single-cycle pulses from the upstream debouncers.
- BCD outputs feed the 7-segment scan driver.

---
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch mode controller: IDLE/RUN/PAUSE/SET sequencing, programmable tick
// divider (1 Hz run, 2 Hz fast adjust) and BCD time registers for the scan driver.
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_clear,
    input  logic       sel,
    input  logic       adj,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       setting,
    output logic       blink,
    output logic       tick,
    output logic       rollover
);

    localparam int DW = $clog2(TICKS_PER_SEC);
    localparam logic [DW-1:0] FULL_LAST = DW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] FAST_LAST = DW'(TICKS_PER_SEC / 2 - 1);
    localparam logic [DW-1:0] FULL_HALF = DW'(TICKS_PER_SEC / 2);
    localparam logic [DW-1:0] FAST_HALF = DW'(TICKS_PER_SEC / 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_SET   = 2'd3
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic            r_running, r_setting, r_blink, r_tick, r_rollover;

    state_t          w_state_nxt;
    logic            w_state_chg;
    logic            w_counting;
    logic [DW-1:0]   w_wrap_at;
    logic            w_wrap;
    logic [DW-1:0]   w_div_nxt;
    logic [DW-1:0]   w_blink_half;
    logic            w_blink_nxt;
    logic [3:0]      w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
    logic            w_roll;

    // Button priority: clear > mode > start, one transition per cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        if (btn_clear) begin
            w_state_nxt = S_IDLE;
        end else if (btn_mode) begin
            case (r_state)
                S_IDLE, S_PAUSE: w_state_nxt = S_SET;
                S_SET:           w_state_nxt = S_PAUSE;
                default:         w_state_nxt = r_state;
            endcase
        end else if (btn_start) begin
            case (r_state)
                S_IDLE, S_PAUSE: w_state_nxt = S_RUN;
                S_RUN:           w_state_nxt = S_PAUSE;
                default:         w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_state_chg  = (w_state_nxt != r_state);
        w_counting   = (r_state == S_RUN) || (r_state == S_SET);
        w_wrap_at    = ((r_state == S_SET) && adj) ? FAST_LAST : FULL_LAST;
        // >= rather than == so an adj 0->1 switch late in a period wraps at once.
        w_wrap       = w_counting && !w_state_chg && (r_div >= w_wrap_at);
        w_div_nxt    = (!w_counting || w_state_chg || w_wrap) ? '0 : r_div + 1'b1;
        w_blink_half = ((w_state_nxt == S_SET) && adj) ? FAST_HALF : FULL_HALF;
        w_blink_nxt  = (w_state_nxt == S_SET) && (w_div_nxt < w_blink_half);
    end

    always_comb begin
        w_min_tens = r_min_tens;
        w_min_ones = r_min_ones;
        w_sec_tens = r_sec_tens;
        w_sec_ones = r_sec_ones;
        w_roll     = 1'b0;
        if (btn_clear) begin
            w_min_tens = '0;
            w_min_ones = '0;
            w_sec_tens = '0;
            w_sec_ones = '0;
        end else if (w_wrap && (r_state == S_RUN)) begin
            if (r_sec_ones != 4'd9) begin
                w_sec_ones = r_sec_ones + 4'd1;
            end else begin
                w_sec_ones = '0;
                if (r_sec_tens != 4'd5) begin
                    w_sec_tens = r_sec_tens + 4'd1;
                end else begin
                    w_sec_tens = '0;
                    if (r_min_ones != 4'd9) begin
                        w_min_ones = r_min_ones + 4'd1;
                    end else begin
                        w_min_ones = '0;
                        if (r_min_tens != 4'd9) begin
                            w_min_tens = r_min_tens + 4'd1;
                        end else begin
                            w_min_tens = '0;
                            w_roll     = 1'b1;
                        end
                    end
                end
            end
        end else if (w_wrap && !sel) begin
            // Seconds field wraps 59 -> 00 on its own in SET.
            if (r_sec_ones != 4'd9) begin
                w_sec_ones = r_sec_ones + 4'd1;
            end else begin
                w_sec_ones = '0;
                w_sec_tens = (r_sec_tens == 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
            end
        end else if (w_wrap) begin
            if (r_min_ones != 4'd9) begin
                w_min_ones = r_min_ones + 4'd1;
            end else begin
                w_min_ones = '0;
                w_min_tens = (r_min_tens == 4'd9) ? 4'd0 : r_min_tens + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_running  <= 1'b0;
            r_setting  <= 1'b0;
            r_blink    <= 1'b0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_min_tens <= w_min_tens;
            r_min_ones <= w_min_ones;
            r_sec_tens <= w_sec_tens;
            r_sec_ones <= w_sec_ones;
            r_running  <= (w_state_nxt == S_RUN);
            r_setting  <= (w_state_nxt == S_SET);
            r_blink    <= w_blink_nxt;
            r_tick     <= w_wrap;
            r_rollover <= w_roll;
        end
    end

    assign min_tens = r_min_tens;
    assign min_ones = r_min_ones;
    assign sec_tens = r_sec_tens;
    assign sec_ones = r_sec_ones;
    assign running  = r_running;
    assign setting  = r_setting;
    assign blink    = r_blink;
    assign tick     = r_tick;
    assign rollover = r_rollover;

endmodule
